ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Shared-bus arbiter for the AHB interconnect. Accepts bus requests and lock requests from up to four masters, selects the bus owner at legal handover points, and drives the `Hmaster` select that steers the master-to-slave address/control/write-data multiplexer. It also drives `Hmaster_data`, which is `Hmaster` delayed by one accepted address phase, for steering write data and response routing in the data phase.

## Interface
- `NUM_MASTERS`, default 4: number of requesters. Legal range is 2..4, because the select is 2 bits.
- `DEFAULT_MASTER`, default 0: owner after reset and when no master is requesting.
- `Hclk`, input, 1: bus clock. All state updates on the rising edge.
- `Hresetn`, input, 1: asynchronous, active-low reset.
- `Hbusreq`, input, [NUM_MASTERS]: per-master bus request.
- `Hlock`, input, [NUM_MASTERS]: per-master locked-transfer request.
- `Htrans`, input, 2: muxed transfer type of the current owner. 00 = IDLE, 01 = BUSY, 10 = NONSEQ, 11 = SEQ.
- `Hburst`, input, 3: muxed burst type. 0 = SINGLE, 1 = INCR, 2/3 = WRAP4/INCR4, 4/5 = WRAP8/INCR8, 6/7 = WRAP16/INCR16.
- `Hready`, input, 1: slave-side ready. 1 means the current address phase is accepted.
- `Hgrant`, output, [NUM_MASTERS]: one-hot grant, equal to the decode of `Hmaster`.
- `Hmaster`, output, 2: address-phase owner index.
- `Hmaster_data`, output, 2: data-phase owner index.
- `Hmastlock`, output, 1: the current address phase is locked.

## Operation
- **Beat counter `rem`** (5 bits): beats left after the current beat of a fixed-length burst.
  - On an accepted NONSEQ, `rem` loads burst length − 1: SINGLE/INCR → 0, 4-beat → 3, 8-beat → 7, 16-beat → 15.
  - On an accepted SEQ, `rem` decrements, saturating at 0.
  - IDLE and BUSY hold `rem`.
- **Handover point (`hp`)** is true when `Hready`=1 and `Hlock[Hmaster]`=0, and any one of these holds:
  - `Htrans`=IDLE.
  - `Htrans`=NONSEQ and `Hburst`=SINGLE.
  - `Htrans`=SEQ, fixed-length burst, and `rem`=1.
  - `Hburst`=INCR, `Htrans` is NONSEQ or SEQ, and `Hbusreq[Hmaster]`=0.
- BUSY is never a handover point.
- **Next-owner selection** at `hp`:
  - Round-robin: search from `Hmaster`+1 upward with wrap, and pick the first index with `Hbusreq` set.
  - If only the current owner requests, the owner is kept.
  - If no master requests, the owner becomes `DEFAULT_MASTER`.
- **Locking:** while the owner's `Hlock`=1, ownership never changes, whatever `Hbusreq` shows.
- `Hmastlock` registers `Hlock[next owner]` on each `Hready`=1 edge.
- Grant state machine: OWN (steady) → HANDOVER (at `hp` with a different next owner) → OWN.
- `Hgrant` is a registered one-hot decode of the new owner.
- **Reset mid-burst:** asynchronous return to the reset state. The interrupted burst is abandoned with no recovery beats.

## Timing
- Reset values:
  - `Hmaster` = `DEFAULT_MASTER`, `Hmaster_data` = `DEFAULT_MASTER`.
  - `Hgrant` = one-hot(`DEFAULT_MASTER`).
  - `Hmastlock` = 0, `rem` = 0.
- `Hmaster` and `Hgrant` update on the rising edge where `hp`=1. The new owner's first address phase is the cycle after that edge.
- `Hmaster_data` takes the old `Hmaster` value on every edge with `Hready`=1, and holds while `Hready`=0.
- `Hready`=0 freezes all state: owner, `rem`, `Hmaster_data`, `Hmastlock`.
- Request-to-grant latency with an idle bus: 1 cycle. Worst case: 16 address-phase beats plus the `Hready` wait states.
- A request that arrives in the same cycle as `hp` is considered in that cycle's arbitration.

## Configuration
- `AHB_ARB_FIXED_PRIO_EN`
  - Defined: next owner is the lowest-index requesting master. There is no rotation, and the owner may be kept even when other masters request.
  - Undefined: round-robin as specified above.
- Handover points, locking and timing are identical in both modes.

## Test plan
- **Reset:** assert `Hresetn`=0 mid-cycle with `DEFAULT_MASTER`=0 → `Hmaster`=0, `Hgrant`=4'b0001, `Hmastlock`=0 immediately, without waiting for a clock edge.
- **Idle grant:** `Hbusreq`=4'b0100, `Htrans`=IDLE, `Hready`=1 → `Hmaster`=2 after 1 edge, and `Hmaster_data`=2 one accepted phase later.
- **Fixed burst:** owner 1 runs INCR4 (NONSEQ then SEQ×3), master 3 requests from the first beat → `Hmaster` stays 1 through 4 accepted beats and changes to 3 on the edge accepting beat 4. With `Hready`=0 for 2 cycles mid-burst, the handover slips by 2 cycles.
- **Round-robin:** all four masters request continuously with SINGLE transfers → owner sequence 0,1,2,3,0. With `AHB_ARB_FIXED_PRIO_EN` defined → owner stays 0.
- **Lock:** owner 2 with `Hlock[2]`=1 issues SINGLE transfers while master 0 requests → `Hmaster`=2 and `Hmastlock`=1 held. When `Hlock[2]` drops, the next `hp` grants 0.
- **INCR release and default:** owner 0 is in an INCR burst and drops `Hbusreq[0]` with no other requests → handover to `DEFAULT_MASTER` on that accepted beat.

Source files
------------

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: picks the bus owner among up to four masters at legal handover points.
// Latency: 1 Hclk from request to grant on an idle bus. All outputs are registered.
// Backpressure: Hready=0 freezes owner, beat count, data-phase owner and lock state.
// Build option: define AHB_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [1:0]             Hmaster,
    output logic [1:0]             Hmaster_data,
    output logic                   Hmastlock
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;

    logic [1:0]             master_q;
    logic [1:0]             master_d;
    logic [1:0]             master_data_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic                   mastlock_q;
    logic                   mastlock_d;
    logic [4:0]             rem_q;
    logic [4:0]             rem_d;
    logic                   owner_lock;
    logic                   owner_req;
    logic [1:0]             sel;
    logic                   fixed_burst;
    logic                   hp;

    // One-hot decode of an owner index into the grant vector.
    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (2'(j) == idx) v[j] = 1'b1;
        end
        return v;
    endfunction

    // Handover detection, next-owner choice and beat-counter next state.
    always_comb begin
        owner_lock = 1'b0;
        owner_req  = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (2'(j) == master_q) begin
                owner_lock = Hlock[j];
                owner_req  = Hbusreq[j];
            end
        end

        // With no requester at all the bus parks on the default master.
        sel = 2'(DEFAULT_MASTER);
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (Hbusreq[j]) sel = 2'(j);
        end
`else
        begin : rr_search
            logic found;
            found = 1'b0;
            // Start one above the owner so the owner itself is checked last.
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                for (int j = 0; j < NUM_MASTERS; j++) begin
                    if (!found && Hbusreq[j] && (j == (int'(master_q) + k) % NUM_MASTERS)) begin
                        found = 1'b1;
                        sel   = 2'(j);
                    end
                end
            end
        end
`endif

        fixed_burst = (Hburst[2:1] != 2'b00);
        hp = Hready && !owner_lock &&
             ((Htrans == TRANS_IDLE) ||
              (Htrans == TRANS_NONSEQ && Hburst == BURST_SINGLE) ||
              (Htrans == TRANS_SEQ && fixed_burst && rem_q == 5'd1) ||
              (Hburst == BURST_INCR && Htrans[1] && !owner_req));

        master_d = hp ? sel : master_q;

        mastlock_d = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (2'(j) == master_d) mastlock_d = Hlock[j];
        end

        rem_d = rem_q;
        if (Htrans == TRANS_NONSEQ) begin
            case (Hburst[2:1])
                2'b01:   rem_d = 5'd3;
                2'b10:   rem_d = 5'd7;
                2'b11:   rem_d = 5'd15;
                default: rem_d = 5'd0;
            endcase
        end else if (Htrans == TRANS_SEQ && rem_q != 5'd0) begin
            rem_d = rem_q - 5'd1;
        end
    end

    // Owner/grant state: every register advances only on accepted address phases.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            master_q      <= 2'(DEFAULT_MASTER);
            master_data_q <= 2'(DEFAULT_MASTER);
            grant_q       <= onehot(2'(DEFAULT_MASTER));
            mastlock_q    <= 1'b0;
            rem_q         <= 5'd0;
        end else if (Hready) begin
            master_q      <= master_d;
            master_data_q <= master_q;
            grant_q       <= onehot(master_d);
            mastlock_q    <= mastlock_d;
            rem_q         <= rem_d;
        end
    end

    assign Hmaster      = master_q;
    assign Hmaster_data = master_data_q;
    assign Hgrant       = grant_q;
    assign Hmastlock    = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with a scoreboard of expected owner state.
// Expectations are queued as each cycle's stimulus is driven and popped after the edge.
// Covers reset, idle grant, fixed burst with wait states, lock, INCR release, arbitration order.
module tb_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;

    logic       Hclk = 1'b0;
    logic       Hresetn;
    logic [3:0] Hbusreq;
    logic [3:0] Hlock;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic       Hready;
    logic [3:0] Hgrant;
    logic [1:0] Hmaster;
    logic [1:0] Hmaster_data;
    logic       Hmastlock;

    typedef struct packed {
        logic [1:0] m;
        logic [1:0] md;
        logic       ml;
        logic [3:0] g;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [1:0] cur_m  = 2'd0;
    logic [1:0] cur_md = 2'd0;

    always #5 Hclk = ~Hclk;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .Hclk         (Hclk),
        .Hresetn      (Hresetn),
        .Hbusreq      (Hbusreq),
        .Hlock        (Hlock),
        .Htrans       (Htrans),
        .Hburst       (Hburst),
        .Hready       (Hready),
        .Hgrant       (Hgrant),
        .Hmaster      (Hmaster),
        .Hmaster_data (Hmaster_data),
        .Hmastlock    (Hmastlock)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [1:0] md, input logic ml);
        exp_t e;
        e.m  = m;
        e.md = md;
        e.ml = ml;
        e.g  = 4'b0001 << m;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".master"},   {30'd0, Hmaster},      {30'd0, e.m});
            chk({tag, ".grant"},    {28'd0, Hgrant},       {28'd0, e.g});
            chk({tag, ".mdata"},    {30'd0, Hmaster_data}, {30'd0, e.md});
            chk({tag, ".mastlock"}, {31'd0, Hmastlock},    {31'd0, e.ml});
        end
    endtask

    // One bus cycle: drive inputs, queue the post-edge expectation, compare after the edge.
    task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy,
                        input logic [1:0] exp_m, input logic exp_ml, input string tag);
        Hbusreq = req;
        Hlock   = lk;
        Htrans  = tr;
        Hburst  = bu;
        Hready  = rdy;
        if (rdy) cur_md = cur_m;
        cur_m = exp_m;
        push_exp(cur_m, cur_md, exp_ml);
        @(posedge Hclk);
        #1;
        compare(tag);
    endtask

    initial begin
        Hresetn = 1'b0;
        Hbusreq = 4'b0000;
        Hlock   = 4'b0000;
        Htrans  = IDLE;
        Hburst  = SINGLE;
        Hready  = 1'b1;
        push_exp(2'd0, 2'd0, 1'b0);
        repeat (2) @(posedge Hclk);
        #1;
        compare("reset");
        Hresetn = 1'b1;

        // Idle bus: request granted on the next edge, data-phase owner follows one phase later.
        step(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 2'd2, 1'b0, "idle_grant");
        step(4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b0, "idle_mdata");

        // Locked owner keeps the bus despite another requester.
        step(4'b0101, 4'b0100, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b1, "lock_1");
        step(4'b0101, 4'b0100, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b1, "lock_2");
        step(4'b0101, 4'b0100, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b1, "lock_3");
        step(4'b0001, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd0, 1'b0, "lock_release");

        // INCR4 by master 1 with two wait states; master 3 takes over on the last beat.
        step(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 2'd1, 1'b0, "fb_grant");
        step(4'b1000, 4'b0000, NONSEQ, INCR4,  1'b1, 2'd1, 1'b0, "fb_beat1");
        step(4'b1000, 4'b0000, SEQ,    INCR4,  1'b1, 2'd1, 1'b0, "fb_beat2");
        step(4'b1000, 4'b0000, SEQ,    INCR4,  1'b0, 2'd1, 1'b0, "fb_wait1");
        step(4'b1000, 4'b0000, SEQ,    INCR4,  1'b0, 2'd1, 1'b0, "fb_wait2");
        step(4'b1000, 4'b0000, SEQ,    INCR4,  1'b1, 2'd1, 1'b0, "fb_beat3");
        step(4'b1000, 4'b0000, SEQ,    INCR4,  1'b1, 2'd3, 1'b0, "fb_beat4");

        // Owner 3 ends an INCR burst by dropping its request: bus parks on master 0.
        step(4'b1000, 4'b0000, NONSEQ, INCR,   1'b1, 2'd3, 1'b0, "incr_beat1");
        step(4'b0000, 4'b0000, SEQ,    INCR,   1'b1, 2'd0, 1'b0, "incr_release");

        // Everyone requesting with SINGLE transfers.
`ifdef AHB_ARB_FIXED_PRIO_EN
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd0, 1'b0, "prio_1");
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd0, 1'b0, "prio_2");
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd0, 1'b0, "prio_3");
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd0, 1'b0, "prio_4");
`else
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd1, 1'b0, "rr_1");
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd2, 1'b0, "rr_2");
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd3, 1'b0, "rr_3");
        step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 2'd0, 1'b0, "rr_4");
`endif

        // Move to a locked non-default owner, then reset asynchronously mid-cycle.
        step(4'b0100, 4'b0100, IDLE,   SINGLE, 1'b1, 2'd2, 1'b1, "pre_reset");
        #3;
        Hresetn = 1'b0;
        cur_m   = 2'd0;
        cur_md  = 2'd0;
        push_exp(2'd0, 2'd0, 1'b0);
        #1;
        compare("async_reset");
        Hbusreq = 4'b0000;
        Hlock   = 4'b0000;
        Htrans  = IDLE;
        Hburst  = SINGLE;
        @(posedge Hclk);
        #1;
        Hresetn = 1'b1;

        // BUSY is never a handover point; Hready low holds a pending handover.
        step(4'b0010, 4'b0000, BUSY,   INCR4,  1'b1, 2'd0, 1'b0, "busy_hold");
        step(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 2'd1, 1'b0, "post_idle");
        step(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b0, 2'd1, 1'b0, "rdy_low");
        step(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 2'd2, 1'b0, "rdy_high");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
